watch_mode_ctrl: RTL

Central button controller for the digital watch. It takes the four debounced key levels and decides which application owns the display: clock, stopwatch or alarm. For the clock and alarm applications it steps through a set-mode field sequence (secs → mins → hours) and drives the HEX-pair flash selects. It emits single-cycle increment/decrement pulses, with auto-repeat on long hold, to the selected counter. It sits between the DEBOUNCE instances and the application counters/HEX mux, and replaces ad-hoc per-app key routing.

---
 rtl/watch_pkg.sv | 15 +
 rtl/key_repeat.sv | 61 ++++++
 rtl/watch_mode_ctrl.sv | 88 ++++++++
 3 files changed

// File: rtl/watch_pkg.sv
// watch_pkg: shared state, app and field codes for the watch button controller
package watch_pkg;
   typedef enum logic [1:0] {RUN, EDIT_SEC, EDIT_MIN, EDIT_HOUR} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_UP, OWN_DOWN} owner_t;
   localparam logic [2:0] APP_CLOCK     = 3'b001;
   localparam logic [2:0] APP_STOPWATCH = 3'b010;
   localparam logic [2:0] APP_ALARM     = 3'b100;
   localparam logic [1:0] FIELD_NONE = 2'd0;
   localparam logic [1:0] FIELD_SEC  = 2'd1;
   localparam logic [1:0] FIELD_MIN  = 2'd2;
   localparam logic [1:0] FIELD_HOUR = 2'd3;
   function automatic logic [2:0] field_flash(input logic [1:0] f);
      return f == FIELD_SEC ? 3'b001 : f == FIELD_MIN ? 3'b010 : f == FIELD_HOUR ? 3'b100 : 3'b000;
   endfunction
endpackage

// File: rtl/key_repeat.sv
// key_repeat: up/down edge-claimed repeat engine with long-hold auto-repeat
//   clk, reset          : clock, async active-high reset
//   up, down            : debounced key levels
//   up_edge, down_edge  : rising edges of the key levels
//   abort               : drop ownership and stay silent this cycle
//   inc, dec            : one-cycle step pulses
//   hold                : auto-repeat active
module key_repeat
   import watch_pkg::*;
#(
   parameter int LONG   = 50_000_000,
   parameter int PERIOD = 5_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic up,
   input  logic down,
   input  logic up_edge,
   input  logic down_edge,
   input  logic abort,
   output logic inc,
   output logic dec,
   output logic hold
);
   localparam int CW = $clog2(LONG > PERIOD ? LONG : PERIOD);
   owner_t owner;
   logic [CW-1:0] cnt;
   logic owned, fire;
   // owned is 0 both with no owner and when the owner has just been released,
   // so a fresh edge may claim the engine in either case
   always_comb begin
      owned = owner == OWN_UP ? up : owner == OWN_DOWN ? down : 1'b0;
      fire = cnt == (hold ? CW'(PERIOD - 1) : CW'(LONG - 1));
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner <= OWN_NONE;
         cnt <= '0;
         hold <= 1'b0;
         inc <= 1'b0;
         dec <= 1'b0;
      end else if (!abort && !owned && (up_edge || down_edge)) begin
         owner <= up_edge ? OWN_UP : OWN_DOWN;
         cnt <= '0;
         hold <= 1'b0;
         inc <= up_edge;
         dec <= !up_edge;
      end else if (abort || !owned) begin
         owner <= OWN_NONE;
         cnt <= '0;
         hold <= 1'b0;
         inc <= 1'b0;
         dec <= 1'b0;
      end else begin
         cnt <= fire ? '0 : cnt + CW'(1);
         hold <= hold | fire;
         inc <= fire && owner == OWN_UP;
         dec <= fire && owner == OWN_DOWN;
      end
   end
endmodule

// File: rtl/watch_mode_ctrl.sv
// watch_mode_ctrl: key router choosing the active app and set-mode field
//   clk, reset                        : clock, async active-high reset
//   key_mode, key_sel, key_up, key_down : debounced key levels, 1 = pressed
//   mux_mode   : one-hot active app (clock / stopwatch / alarm)
//   edit_field : field being set (0 none, 1 secs, 2 mins, 3 hours)
//   flash_sel  : one-hot HEX-pair flash enable
//   inc_pulse, dec_pulse, hold : repeat engine outputs
//   sw_toggle, sw_clear        : stopwatch start/stop and clear pulses
module watch_mode_ctrl
   import watch_pkg::*;
#(
   parameter int LONG    = 50_000_000,
   parameter int PERIOD  = 5_000_000,
   parameter int TIMEOUT = 500_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_mode,
   input  logic       key_sel,
   input  logic       key_up,
   input  logic       key_down,
   output logic [2:0] mux_mode,
   output logic [1:0] edit_field,
   output logic [2:0] flash_sel,
   output logic       inc_pulse,
   output logic       dec_pulse,
   output logic       hold,
   output logic       sw_toggle,
   output logic       sw_clear
);
   localparam int IW = $clog2(TIMEOUT);
   state_t state, state_next;
   logic [IW-1:0] idle;
   logic [3:0] prev;
   logic mode_e, sel_e, up_e, down_e, any_e, abort;
   assign mode_e = key_mode & ~prev[3];
   assign sel_e = key_sel & ~prev[2];
   assign up_e = key_up & ~prev[1];
   assign down_e = key_down & ~prev[0];
   assign any_e = mode_e | sel_e | up_e | down_e;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= RUN;
      else state <= state_next;
   end
   // key_mode beats key_sel; the timeout only fires on a cycle with no edge
   always_comb begin
      state_next = state;
      if (mode_e) state_next = RUN;
      else if (sel_e)
         state_next = state == RUN ? (mux_mode == APP_STOPWATCH ? RUN : EDIT_SEC) :
                      state == EDIT_SEC ? EDIT_MIN : state == EDIT_MIN ? EDIT_HOUR : RUN;
      else if (state != RUN && !any_e && idle == IW'(TIMEOUT - 1)) state_next = RUN;
      abort = state == RUN || state_next != state;
   end
   always_comb begin
      edit_field = state == EDIT_SEC ? FIELD_SEC : state == EDIT_MIN ? FIELD_MIN :
                   state == EDIT_HOUR ? FIELD_HOUR : FIELD_NONE;
      flash_sel = field_flash(edit_field);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev <= 4'b0;
         idle <= '0;
         mux_mode <= APP_CLOCK;
         sw_toggle <= 1'b0;
         sw_clear <= 1'b0;
      end else begin
         prev <= {key_mode, key_sel, key_up, key_down};
         idle <= (state_next == RUN || any_e) ? '0 : idle + IW'(1);
         if (mode_e && state == RUN)
            mux_mode <= mux_mode == APP_CLOCK ? APP_STOPWATCH : mux_mode == APP_STOPWATCH ? APP_ALARM : APP_CLOCK;
         sw_toggle <= state == RUN && mux_mode == APP_STOPWATCH && up_e;
         sw_clear <= state == RUN && mux_mode == APP_STOPWATCH && down_e;
      end
   end
   key_repeat #(.LONG(LONG), .PERIOD(PERIOD)) u_rep (
      .clk(clk),
      .reset(reset),
      .up(key_up),
      .down(key_down),
      .up_edge(up_e),
      .down_edge(down_e),
      .abort(abort),
      .inc(inc_pulse),
      .dec(dec_pulse),
      .hold(hold)
   );
endmodule
